freq_result_fifo: RTL and testbench
===================================

Name: freq_result_fifo

Overview:
- Downstream consumer of the frequency-counter measurement engine in the user project area.
- Captures each (addr, value) result strobe from the counter into a small FIFO and exposes it to the management SoC as a Wishbone slave, so firmware never misses a gate-period result.
- Raises a level interrupt while results are pending.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- TAG_W, 4, width of the counter's result address/tag field.
- DATA_W, 32, width of the measurement value; fixed at 32 (Wishbone word).

Ports:
- clk  in  1  single system clock (Wishbone clock).
- resetn  in  1  synchronous, active-low reset; sampled on rising clk.
- strobe  in  1  one-cycle pulse from the counter: result valid.
- addr  in  TAG_W  result tag (e.g. 1 = frequency count).
- value  in  32  result value.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe; slave is selected by an upstream decoder.
- wb_we_i  in  1  write enable.
- wb_adr_i  in  4  byte address; bits [3:2] select the register, bits [1:0] are ignored.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  single-cycle acknowledge.
- irq_o  out  1  high while the FIFO is non-empty.

Behaviour:
- Reset, while resetn is low at a rising edge:
  - pointers, count, overflow flag, underflow flag and drop counter go to 0.
  - wb_ack_o = 0, wb_dat_o = 0, irq_o = 0.
  - FIFO RAM contents are don't-care.
- Storage: DEPTH entries of {TAG_W tag, 32 value}. Write and read pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Push:
  - When strobe = 1 and (count < DEPTH, or a pop happens in the same cycle), write {addr, value} at wptr, then wptr++.
  - When full with no same-cycle pop: drop the entry, set overflow (sticky), and increment the 8-bit drop counter, saturating at 255.
- Wishbone handshake:
  - wb_ack_o <= wb_cyc_i & wb_stb_i & ~wb_ack_o. Ack arrives one cycle after the request and is never asserted two cycles in a row.
  - All side effects (pop, clear) commit in the cycle ack is asserted.
  - wb_dat_o is registered and valid during ack; it is 0 when ack is low.
- Register map (word offset):
  - 0 STATUS (RO): [7:0] count zero-extended; [8] empty; [9] full; [10] overflow; [11] underflow; [23:16] drop counter; other bits 0.
  - 1 TAG (RO): head tag zero-extended, no pop. Returns 0 when empty.
  - 2 DATA (RO): head value, then pop (rptr++, count--). When empty: returns 0, no pop, sets underflow (sticky).
  - 3 CTRL (WO, reads 0):
    - bit0 = 1 flushes: rptr = wptr, count = 0.
    - bit1 = 1 clears overflow, underflow and the drop counter.
- Writes to registers 0..2 are acked and ignored.
- Simultaneous push and pop:
  - count unchanged; both pointers advance.
  - If the FIFO held exactly one entry, DATA returns the old head and the new entry becomes the head.
  - Push into a full FIFO with a same-cycle pop is accepted.
- Flush in the same cycle as a push: the flush wins and the pushed entry is discarded. The drop counter does not increment and overflow is not set.
- irq_o = (count != 0), registered and updated the same cycle as count.
- Reset mid-transaction: ack drops on the next edge and the pending transaction is lost. The master re-issues it.

Decomposition:
- Shared package freq_pkg holds:
  - register offsets STATUS/TAG/DATA/CTRL = 0..3;
  - STATUS bit positions;
  - CTRL bit positions FLUSH = 0, CLR_ERR = 1;
  - TAG value for the frequency result (TAG_FREQ = 1), shared with the counter.
- One sub-module, freq_fifo_mem: synchronous FIFO with push, pop, flush, full, empty, count and head outputs. The Wishbone/register logic is the top-level wrapper.

Test Plan:
- Reset, then read STATUS -> 0x0000_0100 (empty only); irq_o = 0.
- Strobe addr = 1, value = 0x0000_0123; read TAG -> 1; read DATA -> 0x123; then STATUS -> 0x100 and irq_o falls in the ack cycle.
- Push 10 strobes with values 1..10 into DEPTH = 8 -> STATUS full = 1, overflow = 1, drop = 2. Eight DATA reads return 1..8 in order, then empty.
- Read DATA when empty -> returns 0, underflow = 1. Write CTRL = 0x2 -> STATUS = 0x100.
- With 1 entry (value 0xA), strobe value 0xB in the DATA-ack cycle -> read returns 0xA, count stays 1, next DATA read returns 0xB.
- Fill 3 entries, write CTRL = 0x1 while strobe is high -> count = 0, drop = 0, irq_o = 0. Then wrap test: 20 push/pop pairs return values in order.

Source files
------------

// File: rtl/freq_pkg.sv
// Shared constants for the frequency-counter result path: register map,
// STATUS/CTRL bit positions and the result tag produced by the counter.
package freq_pkg;

  // Word offsets of the Wishbone registers (byte address bits [3:2])
  typedef enum logic [1:0] {
    REG_STATUS = 2'd0,
    REG_TAG    = 2'd1,
    REG_DATA   = 2'd2,
    REG_CTRL   = 2'd3
  } reg_sel_e;

  // STATUS register layout
  localparam int unsigned ST_COUNT_LSB = 0;
  localparam int unsigned ST_EMPTY     = 8;
  localparam int unsigned ST_FULL      = 9;
  localparam int unsigned ST_OVERFLOW  = 10;
  localparam int unsigned ST_UNDERFLOW = 11;
  localparam int unsigned ST_DROP_LSB  = 16;

  // CTRL register layout
  localparam int unsigned CTRL_FLUSH   = 0;
  localparam int unsigned CTRL_CLR_ERR = 1;

  // Tag the counter attaches to a frequency measurement
  localparam int unsigned TAG_FREQ = 1;

  localparam int unsigned DROP_W = 8;

endpackage

// File: rtl/freq_fifo_mem.sv
// Synchronous FIFO: push/pop/flush with same-cycle push+pop when full;
// flush wins over a concurrent push, which is then discarded.
module freq_fifo_mem #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 36
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           head_c,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full_c,
  output logic                   empty_c,
  output logic                   nonempty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  ram [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count_nxt;
  logic          push_ok;
  logic          pop_ok;

  assign full_c  = (count == CW'(DEPTH));
  assign empty_c = (count == '0);
  assign head_c  = ram[rptr];
  assign pop_ok  = pop & ~empty_c & ~flush;
  assign push_ok = push & ~flush & (~full_c | pop_ok);

  // Next occupancy: flush empties, otherwise net of accepted push/pop
  always_comb begin
    count_nxt = count;
    if (flush) count_nxt = '0;
    else       count_nxt = count + CW'(push_ok) - CW'(pop_ok);
  end

  // Pointers, count and registered non-empty flag
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      nonempty <= 1'b0;
    end else begin
      if (flush) begin
        rptr <= wptr;
      end else begin
        if (push_ok) wptr <= wptr + AW'(1);
        if (pop_ok)  rptr <= rptr + AW'(1);
      end
      count    <= count_nxt;
      nonempty <= (count_nxt != '0);
    end
  end

  // Storage array; contents need no reset
  always_ff @(posedge clk) begin
    if (push_ok) ram[wptr] <= din;
  end

endmodule

// File: rtl/freq_result_fifo.sv
// Wishbone slave that buffers (tag, value) results from the frequency
// counter and raises irq_o while any result is pending.
module freq_result_fifo
  import freq_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              strobe,
  input  logic [TAG_W-1:0]  addr,
  input  logic [DATA_W-1:0] value,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [3:0]        wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              irq_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = TAG_W + DATA_W;

  logic [EW-1:0]     head_c;
  logic [CW-1:0]     count;
  logic              full_c;
  logic              empty_c;
  logic              nonempty;
  reg_sel_e          sel_c;
  logic              req_c;
  logic              rd_c;
  logic              wr_c;
  logic              pop_c;
  logic              flush_c;
  logic              clr_c;
  logic              unf_set_c;
  logic              drop_c;
  logic              overflow;
  logic              underflow;
  logic [DROP_W-1:0] drop_cnt;
  logic [31:0]       status_c;
  logic [31:0]       rdata_c;
  logic              unused_bits;

  assign sel_c     = reg_sel_e'(wb_adr_i[3:2]);
  assign req_c     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign rd_c      = req_c & ~wb_we_i;
  assign wr_c      = req_c & wb_we_i;
  assign pop_c     = rd_c & (sel_c == REG_DATA) & ~empty_c;
  assign unf_set_c = rd_c & (sel_c == REG_DATA) & empty_c;
  assign flush_c   = wr_c & (sel_c == REG_CTRL) & wb_dat_i[CTRL_FLUSH];
  assign clr_c     = wr_c & (sel_c == REG_CTRL) & wb_dat_i[CTRL_CLR_ERR];
  assign drop_c    = strobe & full_c & ~pop_c & ~flush_c;
  assign irq_o     = nonempty;
  assign unused_bits = ^{wb_dat_i[31:2], wb_adr_i[1:0]};

  freq_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_mem (
    .clk      (clk),
    .resetn   (resetn),
    .push     (strobe),
    .pop      (pop_c),
    .flush    (flush_c),
    .din      ({addr, value}),
    .head_c   (head_c),
    .count    (count),
    .full_c   (full_c),
    .empty_c  (empty_c),
    .nonempty (nonempty)
  );

  // STATUS word assembly
  always_comb begin
    status_c                         = '0;
    status_c[ST_COUNT_LSB +: 8]      = 8'(count);
    status_c[ST_EMPTY]               = empty_c;
    status_c[ST_FULL]                = full_c;
    status_c[ST_OVERFLOW]            = overflow;
    status_c[ST_UNDERFLOW]           = underflow;
    status_c[ST_DROP_LSB +: DROP_W]  = drop_cnt;
  end

  // Read data mux; head fields read as zero when empty
  always_comb begin
    rdata_c = '0;
    case (sel_c)
      REG_STATUS: rdata_c = status_c;
      REG_TAG:    rdata_c = empty_c ? 32'd0 : 32'(head_c[EW-1 -: TAG_W]);
      REG_DATA:   rdata_c = empty_c ? 32'd0 : 32'(head_c[DATA_W-1:0]);
      default:    rdata_c = '0;
    endcase
  end

  // Wishbone ack and registered read data
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= req_c;
      wb_dat_o <= rd_c ? rdata_c : 32'd0;
    end
  end

  // Sticky error flags and saturating drop counter; a new error in the
  // clear cycle is kept so it is not lost
  always_ff @(posedge clk) begin
    if (!resetn) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      drop_cnt  <= '0;
    end else if (clr_c) begin
      overflow  <= drop_c;
      underflow <= 1'b0;
      drop_cnt  <= DROP_W'(drop_c);
    end else begin
      if (drop_c) overflow <= 1'b1;
      if (unf_set_c) underflow <= 1'b1;
      if (drop_c && drop_cnt != {DROP_W{1'b1}}) drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

endmodule

// File: tb/tb_freq_result_fifo.sv
// Scoreboard bench: each Wishbone access queues its expected read data and a
// negedge monitor compares whenever wb_ack_o is presented.
module tb_freq_result_fifo;
  import freq_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        strobe;
  logic [3:0]  addr;
  logic [31:0] value;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        irq_o;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  string       nm_q[$];
  logic        irq_at_ack;
  logic        prev_ack = 1'b0;

  always #5 clk = ~clk;

  freq_result_fifo #(.DEPTH(8), .TAG_W(4), .DATA_W(32)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .strobe   (strobe),
    .addr     (addr),
    .value    (value),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .irq_o    (irq_o)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Expected STATUS word from hand-tracked FIFO state
  function automatic logic [31:0] st(input int cnt, input bit full, input bit ovf,
                                     input bit unf, input int drop);
    logic [31:0] s;
    s = 32'(cnt) & 32'hFF;
    s[8]  = (cnt == 0);
    s[9]  = full;
    s[10] = ovf;
    s[11] = unf;
    s[23:16] = 8'(drop);
    return s;
  endfunction

  // Monitor: every ack pops one expectation
  always @(negedge clk) begin
    if (wb_ack_o) begin
      if (prev_ack) check("ack_back_to_back", 32'(wb_ack_o), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'(wb_ack_o), 32'd0);
      end else begin
        check(nm_q.pop_front(), wb_dat_o, exp_q.pop_front());
      end
    end
    prev_ack = wb_ack_o;
  end

  // One Wishbone access, optionally with a result strobe in the same cycle
  task automatic wb_xfer(input logic we, input reg_sel_e r, input logic [31:0] wdat,
                         input logic [31:0] exp, input string nm,
                         input bit do_strobe, input logic [31:0] sval);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = {r, 2'b00}; wb_dat_i = wdat;
    if (do_strobe) begin strobe = 1'b1; addr = 4'(TAG_FREQ); value = sval; end
    exp_q.push_back(exp); nm_q.push_back(nm);
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; strobe = 1'b0;
    irq_at_ack = irq_o;
    @(posedge clk); #1;
  endtask

  task automatic rd(input reg_sel_e r, input logic [31:0] exp, input string nm);
    wb_xfer(1'b0, r, 32'd0, exp, nm, 1'b0, 32'd0);
  endtask

  task automatic wr(input reg_sel_e r, input logic [31:0] d);
    wb_xfer(1'b1, r, d, 32'd0, "write_data", 1'b0, 32'd0);
  endtask

  task automatic push(input logic [31:0] v);
    strobe = 1'b1; addr = 4'(TAG_FREQ); value = v;
    @(posedge clk); #1;
    strobe = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; strobe = 1'b0; addr = '0; value = '0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_adr_i = '0; wb_dat_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_irq", 32'(irq_o), 32'd0);
    check("reset_ack", 32'(wb_ack_o), 32'd0);
    check("reset_dat", wb_dat_o, 32'd0);
    resetn = 1'b1;

    rd(REG_STATUS, st(0, 0, 0, 0, 0), "status_after_reset");
    rd(REG_TAG, 32'd0, "tag_when_empty");

    // Single result
    push(32'h0000_0123);
    check("irq_after_push", 32'(irq_o), 32'd1);
    rd(REG_TAG, 32'd1, "tag_head");
    rd(REG_DATA, 32'h123, "data_single");
    check("irq_falls_in_ack", 32'(irq_at_ack), 32'd0);
    rd(REG_STATUS, st(0, 0, 0, 0, 0), "status_after_pop");

    // Overflow: 10 results into 8 entries
    for (int i = 1; i <= 10; i++) push(32'(i));
    rd(REG_STATUS, st(8, 1, 1, 0, 2), "status_overflow");
    for (int i = 1; i <= 8; i++) rd(REG_DATA, 32'(i), "data_order");
    rd(REG_STATUS, st(0, 0, 1, 0, 2), "status_drained");

    // Underflow and error clear
    rd(REG_DATA, 32'd0, "data_underflow");
    rd(REG_STATUS, st(0, 0, 1, 1, 2), "status_underflow");
    wr(REG_STATUS, 32'hFFFF_FFFF);
    rd(REG_STATUS, st(0, 0, 1, 1, 2), "status_write_ignored");
    wr(REG_CTRL, 32'h2);
    rd(REG_STATUS, st(0, 0, 0, 0, 0), "status_cleared");

    // Push and pop together with one entry held
    push(32'hA);
    wb_xfer(1'b0, REG_DATA, 32'd0, 32'hA, "data_pushpop_old", 1'b1, 32'hB);
    rd(REG_STATUS, st(1, 0, 0, 0, 0), "status_pushpop_count");
    rd(REG_DATA, 32'hB, "data_pushpop_new");

    // Flush wins over a same-cycle push
    for (int i = 0; i < 3; i++) push(32'h50 + 32'(i));
    rd(REG_STATUS, st(3, 0, 0, 0, 0), "status_three");
    wb_xfer(1'b1, REG_CTRL, 32'h1, 32'd0, "write_data", 1'b1, 32'h99);
    rd(REG_STATUS, st(0, 0, 0, 0, 0), "status_flushed");
    check("irq_after_flush", 32'(irq_o), 32'd0);

    // Flush while full with a strobe: no drop counted
    for (int i = 0; i < 8; i++) push(32'h60 + 32'(i));
    wb_xfer(1'b1, REG_CTRL, 32'h1, 32'd0, "write_data", 1'b1, 32'h77);
    rd(REG_STATUS, st(0, 0, 0, 0, 0), "status_flush_full");

    // Push into a full FIFO with same-cycle pop is accepted
    for (int i = 0; i < 8; i++) push(32'h200 + 32'(i));
    wb_xfer(1'b0, REG_DATA, 32'd0, 32'h200, "data_full_pushpop", 1'b1, 32'h208);
    rd(REG_STATUS, st(8, 1, 0, 0, 0), "status_full_pushpop");
    for (int i = 1; i <= 8; i++) rd(REG_DATA, 32'h200 + 32'(i), "data_full_drain");

    // Pointer wrap with 20 push/pop pairs
    for (int i = 0; i < 20; i++) begin
      push(32'h1000 + 32'(i));
      rd(REG_DATA, 32'h1000 + 32'(i), "data_wrap");
    end
    rd(REG_STATUS, st(0, 0, 0, 0, 0), "status_final");
    check("irq_final", 32'(irq_o), 32'd0);

    // Bounded drain: any expectation still queued never saw its ack
    repeat (4) @(posedge clk);
    while (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      check({"missing_ack_", nm_q.pop_front()}, 32'd0, 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
